// File: rtl/n1_ips_pkg.sv
// n1_ips_pkg: shared types for the intermediate parameter stack cache.
// Holds the cell width, the FSM state enum and the cell-array opcodes.
package n1_ips_pkg;

  localparam int unsigned CELL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPILL,
    ST_FILL_ADJ,
    ST_FILL_RD
  } ips_st_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_PULL,
    OP_REPL,
    OP_SPILL,
    OP_FILL
  } cell_op_e;

endpackage

// File: rtl/n1_ips_cells.sv
// n1_ips_cells: DEPTH-cell stack cache, cell 0 is top of stack.
// Ports: clk_i, async_rst_i, clr_i (sync clear), op_i/dat_i (operation),
//        top_o (cell 0), bot_o (cell DEPTH-1), cnt_o (occupied cells).
module n1_ips_cells
  import n1_ips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              async_rst_i,
  input  logic              clr_i,
  input  cell_op_e          op_i,
  input  logic [CELL_W-1:0] dat_i,
  output logic [CELL_W-1:0] top_o,
  output logic [CELL_W-1:0] bot_o,
  output logic [CW-1:0]     cnt_o
);

  logic [CELL_W-1:0] cell_q [DEPTH];
  logic [CELL_W-1:0] cell_d [DEPTH];
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  // Cells at or beyond cnt are kept zero so an emptied cache reads 0.
  // Only a replace on an empty cache leaves data in cell 0.
  always_comb begin
    cell_d = cell_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cell_d = '{default: '0};
      cnt_d  = '0;
    end else begin
      unique case (op_i)
        OP_PUSH: begin
          cell_d[0] = dat_i;
          for (int i = 1; i < int'(DEPTH); i++)
            cell_d[i] = (i <= int'(cnt_q)) ? cell_q[i-1] : '0;
          cnt_d = cnt_q + CW'(1);
        end
        OP_PULL: begin
          for (int i = 0; i < int'(DEPTH) - 1; i++)
            cell_d[i] = cell_q[i+1];
          cell_d[DEPTH-1] = '0;
          if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        end
        OP_REPL: cell_d[0] = dat_i;
        OP_SPILL: begin
          cell_d[DEPTH-1] = '0;
          cnt_d = cnt_q - CW'(1);
        end
        OP_FILL: begin
          for (int i = 0; i < int'(DEPTH); i++)
            if (i == int'(cnt_q))
              cell_d[i] = dat_i;
          cnt_d = cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      cell_q <= '{default: '0};
      cnt_q  <= '0;
    end else begin
      cell_q <= cell_d;
      cnt_q  <= cnt_d;
    end
  end

  assign top_o = cell_q[0];
  assign bot_o = cell_q[DEPTH-1];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/n1_ips.sv
// n1_ips: register stack cache that spills to / fills from RAM.
// Ports: ups2ips_* request side, ips2ups_* ack/top/{ovf,unf}; ips2ram_* /
//        ram2ips_* RAM bus; ips2dsp_psh/pul/rst_o AGU pulses, dsp2ips_lsp_i.
// Macro N1_IPS_PREFETCH_EN enables autonomous fills when cache runs low.
module n1_ips
  import n1_ips_pkg::*;
#(
  parameter int unsigned SP_WIDTH = 12,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  input  logic                ups2ips_push_i,
  input  logic                ups2ips_pull_i,
  input  logic                ups2ips_clr_i,
  input  logic [CELL_W-1:0]   ups2ips_dat_i,
  output logic                ips2ups_ack_o,
  output logic [CELL_W-1:0]   ips2ups_dat_o,
  output logic [1:0]          ips2ups_err_o,
  output logic                ips2ram_cyc_o,
  output logic                ips2ram_we_o,
  output logic [SP_WIDTH-1:0] ips2ram_adr_o,
  output logic [CELL_W-1:0]   ips2ram_dat_o,
  input  logic                ram2ips_ack_i,
  input  logic [CELL_W-1:0]   ram2ips_dat_i,
  output logic                ips2dsp_psh_o,
  output logic                ips2dsp_pul_o,
  output logic                ips2dsp_rst_o,
  input  logic [SP_WIDTH-1:0] dsp2ips_lsp_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [SP_WIDTH:0] RC_ONE = {{SP_WIDTH{1'b0}}, 1'b1};

  ips_st_e           state_q, state_d;
  logic [SP_WIDTH:0] rcnt_q, rcnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  cell_op_e          op;
  logic [CELL_W-1:0] cell_dat;
  logic [CELL_W-1:0] top, bot;
  logic [CW-1:0]     cnt;

  logic full, empty, rfull, rempty;
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign rfull  = rcnt_q[SP_WIDTH];
  assign rempty = (rcnt_q == '0);

  n1_ips_cells #(.DEPTH(DEPTH)) u_cells (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .clr_i       (ups2ips_clr_i),
    .op_i        (op),
    .dat_i       (cell_dat),
    .top_o       (top),
    .bot_o       (bot),
    .cnt_o       (cnt)
  );

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    op            = OP_NONE;
    cell_dat      = ups2ips_dat_i;
    ips2ups_ack_o = 1'b0;
    ips2ram_cyc_o = 1'b0;
    ips2ram_we_o  = 1'b0;
    ips2dsp_psh_o = 1'b0;
    ips2dsp_pul_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ups2ips_push_i && ups2ips_pull_i) begin
          ips2ups_ack_o = 1'b1;
          op = OP_REPL;
        end else if (ups2ips_push_i) begin
          if (!full) begin
            ips2ups_ack_o = 1'b1;
            op = OP_PUSH;
          end else if (rfull) begin
            ips2ups_ack_o = 1'b1;
            ovf_d = 1'b1;
          end else begin
            state_d = ST_SPILL;
          end
        end else if (ups2ips_pull_i) begin
          if (!empty) begin
            ips2ups_ack_o = 1'b1;
            op = OP_PULL;
          end else if (rempty) begin
            // Shift in the zero below so the top reads 0.
            ips2ups_ack_o = 1'b1;
            unf_d = 1'b1;
            op = OP_PULL;
          end else begin
            state_d = ST_FILL_ADJ;
          end
        end
`ifdef N1_IPS_PREFETCH_EN
        else if ((cnt <= CW'(1)) && !rempty) begin
          state_d = ST_FILL_ADJ;
        end
`else
        else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_SPILL: begin
        ips2ram_cyc_o = 1'b1;
        ips2ram_we_o  = 1'b1;
        if (ram2ips_ack_i) begin
          ips2dsp_psh_o = 1'b1;
          op      = OP_SPILL;
          rcnt_d  = rcnt_q + RC_ONE;
          state_d = ST_IDLE;
        end
      end
      ST_FILL_ADJ: begin
        // AGU moves lsp onto the newest RAM entry before the read.
        ips2dsp_pul_o = 1'b1;
        state_d = ST_FILL_RD;
      end
      ST_FILL_RD: begin
        ips2ram_cyc_o = 1'b1;
        if (ram2ips_ack_i) begin
          op       = OP_FILL;
          cell_dat = ram2ips_dat_i;
          rcnt_d   = rcnt_q - RC_ONE;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ups2ips_clr_i) begin
      state_d       = ST_IDLE;
      rcnt_d        = '0;
      ovf_d         = 1'b0;
      unf_d         = 1'b0;
      op            = OP_NONE;
      ips2ups_ack_o = 1'b0;
      ips2dsp_psh_o = 1'b0;
      ips2dsp_pul_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ips2ups_dat_o = top;
  assign ips2ups_err_o = {ovf_q, unf_q};
  assign ips2ram_adr_o = dsp2ips_lsp_i;
  assign ips2ram_dat_o = bot;
  assign ips2dsp_rst_o = ups2ips_clr_i;

endmodule

// File: tb/tb_n1_ips.sv
// tb_n1_ips: vector table, hand sequences and random ops against a
// queue-based stack model, with a RAM and DSP AGU model in the bench.
module tb_n1_ips;

  localparam int SPW = 12;
  localparam int D   = 4;
  localparam int CAP = D + (1 << SPW);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, pull, clr;
  logic [15:0] din;
  logic        ram_ack;
  logic [15:0] ram_dat;
  logic [11:0] lsp;
  logic        ack;
  logic [15:0] dat;
  logic [1:0]  err;
  logic        cyc, we;
  logic [11:0] adr;
  logic [15:0] wdat;
  logic        psh, pul, rst;

  always #5 clk = ~clk;

  n1_ips #(.SP_WIDTH(SPW), .DEPTH(D)) dut (
    .clk_i          (clk),
    .async_rst_i    (rst_n),
    .ups2ips_push_i (push),
    .ups2ips_pull_i (pull),
    .ups2ips_clr_i  (clr),
    .ups2ips_dat_i  (din),
    .ips2ups_ack_o  (ack),
    .ips2ups_dat_o  (dat),
    .ips2ups_err_o  (err),
    .ips2ram_cyc_o  (cyc),
    .ips2ram_we_o   (we),
    .ips2ram_adr_o  (adr),
    .ips2ram_dat_o  (wdat),
    .ram2ips_ack_i  (ram_ack),
    .ram2ips_dat_i  (ram_dat),
    .ips2dsp_psh_o  (psh),
    .ips2dsp_pul_o  (pul),
    .ips2dsp_rst_o  (rst),
    .dsp2ips_lsp_i  (lsp)
  );

  logic [15:0] mem [4096];
  bit          ram_auto;
  int          cyc_n;
  int          n_cmp, n_bad;

  logic        s_ack, s_cyc, s_we, s_psh, s_pul, s_rst;
  logic [11:0] s_adr;
  logic [15:0] s_wdat, s_dat;

  int          lat, psh_at, pul_at, cyc_at;
  logic [11:0] cyc_adr;
  logic        cyc_we;
  logic [15:0] cyc_wdat, ack_dat;

  typedef struct {
    bit          p;
    bit          q;
    logic [15:0] d;
    int          lat;
    logic [15:0] dat;
    logic [1:0]  err;
  } vec_t;
  vec_t tv [13];

  logic [15:0] stk [$];
  int          mc;
  logic [15:0] ghost;
  bit          movf, munf;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: RAM answers 2 cycles after cyc rises, AGU follows pulses.
  task automatic cycle();
    if (ram_auto) begin
      if (cyc) begin
        cyc_n++;
        if (cyc_n == 3) begin
          ram_ack = 1'b1;
          cyc_n = 0;
          if (we) mem[adr] = wdat;
          else ram_dat = mem[adr];
        end else begin
          ram_ack = 1'b0;
        end
      end else begin
        cyc_n = 0;
        ram_ack = 1'b0;
      end
    end
    #1;
    s_ack = ack; s_cyc = cyc; s_we = we;
    s_psh = psh; s_pul = pul; s_rst = rst;
    s_adr = adr; s_wdat = wdat; s_dat = dat;
    @(posedge clk);
    if (s_rst) lsp = '0;
    else if (s_psh) lsp = lsp - 12'd1;
    else if (s_pul) lsp = lsp + 12'd1;
    @(negedge clk);
  endtask

  task automatic do_op(input bit p, input bit q, input logic [15:0] d);
    push = p; pull = q; din = d;
    lat = -1; psh_at = -1; pul_at = -1; cyc_at = -1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (s_psh && psh_at < 0) psh_at = k;
      if (s_pul && pul_at < 0) pul_at = k;
      if (s_cyc && cyc_at < 0) begin
        cyc_at = k; cyc_adr = s_adr;
        cyc_we = s_we; cyc_wdat = s_wdat;
      end
      if (s_ack) begin
        lat = k; ack_dat = s_dat;
        break;
      end
    end
    push = 1'b0; pull = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: got none want ack in 24 cycles");
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_rst_pulse", int'(s_rst), 1);
  endtask

  function automatic logic [15:0] v(input int i);
    return 16'(i * 7 + 3);
  endfunction

  initial begin
    int r, explat;
    bit popchk;
    logic [15:0] d, expv;
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    tv[0]  = '{1, 0, 16'd1, 0, 16'd1, 2'b00};
    tv[1]  = '{1, 0, 16'd2, 0, 16'd2, 2'b00};
    tv[2]  = '{1, 0, 16'd3, 0, 16'd3, 2'b00};
    tv[3]  = '{1, 0, 16'd4, 0, 16'd4, 2'b00};
    tv[4]  = '{1, 1, 16'd9, 0, 16'd9, 2'b00};
    tv[5]  = '{0, 1, 16'd0, 0, 16'd3, 2'b00};
    tv[6]  = '{0, 1, 16'd0, 0, 16'd2, 2'b00};
    tv[7]  = '{0, 1, 16'd0, 0, 16'd1, 2'b00};
    tv[8]  = '{0, 1, 16'd0, 0, 16'd0, 2'b00};
    tv[9]  = '{1, 1, 16'd7, 0, 16'd7, 2'b00};
    tv[10] = '{0, 1, 16'd0, 0, 16'd0, 2'b01};
    tv[11] = '{1, 0, 16'd5, 0, 16'd5, 2'b01};
    tv[12] = '{0, 1, 16'd0, 0, 16'd0, 2'b01};

    rst_n = 1'b0; push = 0; pull = 0; clr = 0; din = '0;
    ram_ack = 0; ram_dat = '0; lsp = 12'h5A5;
    ram_auto = 1; cyc_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_dat", int'(dat), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cyc", int'(cyc), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_pulses", int'({psh, pul, rst}), 0);
    chk("rst_adr", int'(adr), 'h5A5);
    lsp = '0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_op(tv[i].p, tv[i].q, tv[i].d);
      chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("tv%0d_nocyc", i), cyc_at, -1);
      chk($sformatf("tv%0d_dat", i), int'(dat), int'(tv[i].dat));
      chk($sformatf("tv%0d_err", i), int'(err), int'(tv[i].err));
    end
    do_clr();
    chk("clr_err", int'(err), 0);

    // Spill on the fifth push.
    for (int i = 1; i <= 4; i++) do_op(1, 0, 16'(i));
    do_op(1, 0, 16'd5);
    chk("spill_lat", lat, 4);
    chk("spill_cyc_at", cyc_at, 1);
    chk("spill_we", int'(cyc_we), 1);
    chk("spill_adr", int'(cyc_adr), 0);
    chk("spill_wdat", int'(cyc_wdat), 1);
    chk("spill_psh_at", psh_at, 3);
    chk("spill_mem", int'(mem[0]), 1);
    chk("spill_dat", int'(dat), 5);
    chk("spill_lsp", int'(lsp), 'hFFF);

    // Drain the cache, then fill from RAM.
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1, '0);
      chk("drain_lat", lat, 0);
      expv = (i == 3) ? 16'd0 : 16'(4 - i);
      chk("drain_dat", int'(dat), int'(expv));
    end
    do_op(0, 1, '0);
    chk("fill_lat", lat, 5);
    chk("fill_pul_at", pul_at, 1);
    chk("fill_cyc_at", cyc_at, 2);
    chk("fill_we", int'(cyc_we), 0);
    chk("fill_adr", int'(cyc_adr), 0);
    chk("fill_val", int'(ack_dat), 1);
    chk("fill_err", int'(err), 0);

    // Clear while a spill waits on RAM.
    for (int i = 1; i <= 4; i++) do_op(1, 0, 16'(i + 20));
    ram_auto = 0; ram_ack = 0;
    push = 1; din = 16'd99;
    cycle();
    cycle();
    chk("cspill_cyc", int'(s_cyc), 1);
    push = 0; clr = 1;
    cycle();
    chk("cspill_rst", int'(s_rst), 1);
    chk("cspill_ack", int'(s_ack), 0);
    clr = 0; ram_ack = 1;
    cycle();
    chk("cspill_cyc_off", int'(s_cyc), 0);
    chk("cspill_late_psh", int'(s_psh), 0);
    chk("cspill_late_ack", int'(s_ack), 0);
    ram_ack = 0; ram_auto = 1; cyc_n = 0;
    chk("cspill_dat", int'(dat), 0);
    do_op(0, 1, '0);
    chk("cspill_empty_lat", lat, 0);
    chk("cspill_empty_err", int'(err), 1);
    do_clr();

    // Fill cache and all of RAM, then one more push overflows.
    for (int i = 0; i < CAP; i++) begin
      do_op(1, 0, v(i));
      chk("ovf_fill_lat", lat, (i < D) ? 0 : 4);
    end
    do_op(1, 0, 16'hDEAD);
    chk("ovf_lat", lat, 0);
    chk("ovf_nocyc", cyc_at, -1);
    chk("ovf_err", int'(err), 2);
    chk("ovf_dat", int'(dat), int'(v(CAP - 1)));
    for (int j = 0; j < 5; j++) begin
      do_op(0, 1, '0);
      chk("ovf_pull_lat", lat, (j < 4) ? 0 : 5);
      chk("ovf_pull_val", int'(ack_dat), int'(v(CAP - 1 - j)));
    end
    chk("ovf_sticky", int'(err), 2);
    do_clr();

    // Random ops against the queue model.
    stk.delete(); mc = 0; ghost = '0; movf = 0; munf = 0;
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      d = 16'($urandom);
      if (r < 4) begin
        do_clr();
        stk.delete(); mc = 0; ghost = '0; movf = 0; munf = 0;
        chk("rnd_clr_err", int'(err), 0);
        chk("rnd_clr_dat", int'(dat), 0);
        continue;
      end
      popchk = 0; expv = '0; explat = 0;
      if (r < 14) begin
        if (mc > 0) stk[0] = d; else ghost = d;
        do_op(1, 1, d);
      end else if (r < 57) begin
        if (stk.size() == CAP) movf = 1;
        else begin
          explat = (mc < D) ? 0 : 4;
          if (mc < D) mc++;
          stk.push_front(d);
        end
        do_op(1, 0, d);
      end else begin
        if (stk.size() == 0) begin
          munf = 1; ghost = '0;
        end else begin
          if (mc > 0) mc--; else explat = 5;
          expv = stk.pop_front();
          popchk = 1;
          if (mc == 0) ghost = '0;
        end
        do_op(0, 1, '0);
      end
      chk("rnd_lat", lat, explat);
      if (popchk) chk("rnd_pull_val", int'(ack_dat), int'(expv));
      chk("rnd_dat", int'(dat), int'((mc > 0) ? stk[0] : ghost));
      chk("rnd_err", int'(err), int'({movf, munf}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
